// File: rtl/cam_seq_if.sv
// cam_seq_if: Nios command/status and CCD frame handshake bundle for cam_capture_sequencer
//   master: Nios/CCD side (drives cmd_start, cmd_abort, cmd_ack, frame_valid)
//   slave : sequencer side (drives run_pulse, capture_pulse, busy, done, error, frame_count)
interface cam_seq_if #(parameter int FCNT_W = 16);
  logic              cmd_start;
  logic              cmd_abort;
  logic              cmd_ack;
  logic              frame_valid;
  logic              run_pulse;
  logic              capture_pulse;
  logic              busy;
  logic              done;
  logic              error;
  logic [FCNT_W-1:0] frame_count;
  modport master (
    output cmd_start, cmd_abort, cmd_ack, frame_valid,
    input  run_pulse, capture_pulse, busy, done, error, frame_count
  );
  modport slave (
    input  cmd_start, cmd_abort, cmd_ack, frame_valid,
    output run_pulse, capture_pulse, busy, done, error, frame_count
  );
endinterface

// File: rtl/cam_capture_sequencer.sv
// cam_capture_sequencer: single-frame CCD capture sequencing on a Nios start command
//   clk    : pixel clock, all inputs synchronous to it
//   resetN : asynchronous active-low reset
//   bus    : cam_seq_if.slave (Nios commands, CCD frame_valid, registered status/pulses)
//   Optional watchdog enabled by defining CAM_SEQ_TIMEOUT_EN; otherwise error never asserts.
module cam_capture_sequencer #(
  parameter int SKIP_FRAMES    = 2,
  parameter int FCNT_W         = 16,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input logic      clk,
  input logic      resetN,
  cam_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START_RUN, SKIP, ARM, WAIT_START, WAIT_END, DONE, ERROR} state_t;
  localparam int SKW = $clog2(SKIP_FRAMES + 2);
  state_t            state_q, state_d;
  logic              start_dly_q, start_dly_d;
  logic              fv_dly_q, fv_dly_d;
  logic [SKW-1:0]    skip_cnt_q, skip_cnt_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;
  logic              run_pulse_q, run_pulse_d;
  logic              capture_pulse_q, capture_pulse_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              start_rise, fv_rise, fv_fall, active, timeout;
  assign start_rise = bus.cmd_start & ~start_dly_q;
  assign fv_rise    = bus.frame_valid & ~fv_dly_q;
  assign fv_fall    = ~bus.frame_valid & fv_dly_q;
  assign active     = state_q inside {SKIP, ARM, WAIT_START, WAIT_END};
`ifdef CAM_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
  // Restarted when leaving START_RUN (entry to SKIP/ARM) and on every frame edge.
  always_comb
    wd_d = (state_q == START_RUN || fv_rise || fv_fall) ? '0 :
           active ? wd_q + 1'b1 : wd_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) wd_q <= '0;
    else         wd_q <= wd_d;
  assign timeout = active && wd_q == WDW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    start_dly_d   = bus.cmd_start;
    fv_dly_d      = bus.frame_valid;
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    frame_count_d = (state_q != IDLE && state_q != DONE && state_q != ERROR && fv_fall && frame_count_q != '1)
                    ? frame_count_q + 1'b1 : frame_count_q;
    if (bus.cmd_abort) state_d = IDLE;
    else if (timeout) state_d = ERROR;
    else
      case (state_q)
        IDLE:
          if (start_rise) begin
            state_d       = START_RUN;
            frame_count_d = '0;
            skip_cnt_d    = '0;
          end
        START_RUN:  state_d = (SKIP_FRAMES == 0) ? ARM : SKIP;
        SKIP:
          if (skip_cnt_q == SKW'(SKIP_FRAMES)) state_d = ARM;
          else if (fv_fall) skip_cnt_d = skip_cnt_q + 1'b1;
        // Arm only in the blank so capture applies to a whole upcoming frame.
        ARM:        state_d = bus.frame_valid ? ARM : WAIT_START;
        WAIT_START: state_d = fv_rise ? WAIT_END : WAIT_START;
        WAIT_END:   state_d = fv_fall ? DONE : WAIT_END;
        DONE:       state_d = bus.cmd_ack ? IDLE : DONE;
        ERROR:      state_d = bus.cmd_ack ? IDLE : ERROR;
        default:    state_d = IDLE;
      endcase
    // Outputs are decoded from the next state so they register in step with it.
    run_pulse_d     = state_q == IDLE && state_d == START_RUN;
    capture_pulse_d = state_q == ARM && state_d == WAIT_START;
    busy_d          = state_d inside {START_RUN, SKIP, ARM, WAIT_START, WAIT_END};
    done_d          = state_d == DONE;
    error_d         = state_d == ERROR;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q         <= IDLE;
      start_dly_q     <= 1'b0;
      fv_dly_q        <= 1'b0;
      skip_cnt_q      <= '0;
      frame_count_q   <= '0;
      run_pulse_q     <= 1'b0;
      capture_pulse_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_dly_q     <= start_dly_d;
      fv_dly_q        <= fv_dly_d;
      skip_cnt_q      <= skip_cnt_d;
      frame_count_q   <= frame_count_d;
      run_pulse_q     <= run_pulse_d;
      capture_pulse_q <= capture_pulse_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  assign bus.run_pulse     = run_pulse_q;
  assign bus.capture_pulse = capture_pulse_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.frame_count   = frame_count_q;
endmodule

// File: doc/cam_capture_sequencer.md
# cam_capture_sequencer

Sequences the CCD camera for a single-frame capture on a Nios command. On a start request it pulses the CCD run input, discards a fixed number of settling frames, then pulses capture between frames. It tracks the captured frame from start to end and reports done, or error if the watchdog fires. It sits between the Nios PIO command/status registers and the CCD capture module, in the pixel-clock domain.

## Interface
- SKIP_FRAMES, default 2: complete frames discarded after run start before capture is armed (0 allowed).
- FCNT_W, default 16: width of frame_count.
- TIMEOUT_CYCLES, default 5000000: watchdog limit in clk cycles between frame_valid edges (only with CAM_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  pixel clock; all inputs synchronous to it.
- resetN  in  1  asynchronous, active-low reset.
- cmd_start  in  1  Nios level; rising edge requests a sequence.
- cmd_abort  in  1  Nios level; high returns the block to IDLE.
- cmd_ack  in  1  Nios level; high in DONE/ERROR returns the block to IDLE.
- frame_valid  in  1  CCD frame-active flag.
- run_pulse  out  1  one-cycle pulse: start CCD running.
- capture_pulse  out  1  one-cycle pulse: CCD captures next frame.
- busy  out  1  high in START_RUN, SKIP, ARM, WAIT_START, WAIT_END.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- frame_count  out  FCNT_W  frames ended since the last START_RUN.

## Operation
- Registered copies start_d and fv_d, both reset 0.
  - start_rise = cmd_start & ~start_d.
  - fv_rise = frame_valid & ~fv_d.
  - fv_fall = ~frame_valid & fv_d.
- States, in priority order per cycle:
  - cmd_abort high in any state: go to IDLE and clear all outputs except frame_count. Abort beats a simultaneous start_rise.
  - IDLE: start_rise → START_RUN. Clear frame_count and the skip counter. Set run_pulse.
  - START_RUN: clear run_pulse. Go to SKIP, or to ARM if SKIP_FRAMES == 0.
  - SKIP: each fv_fall increments the skip counter. When the counter reaches SKIP_FRAMES → ARM.
  - ARM: when frame_valid is low (between frames), set capture_pulse → WAIT_START. If frame_valid is high, wait.
  - WAIT_START: clear capture_pulse. fv_rise → WAIT_END.
  - WAIT_END: fv_fall → DONE.
  - DONE / ERROR: hold until cmd_ack is high, then → IDLE. start_rise is ignored in these states.
- frame_count increments on every fv_fall while state ∉ {IDLE, DONE, ERROR}. It saturates at all-ones and keeps its value in IDLE/DONE/ERROR.
- start_rise outside IDLE is ignored; it does not restart the sequence.

## Timing
- Reset values: state IDLE; run_pulse, capture_pulse, busy, done, error all 0; frame_count 0; counters 0.
- All outputs are registered, with no combinational path from input to output.
- run_pulse is high for exactly the one cycle after the edge that sampled start_rise. busy rises in that same cycle.
- capture_pulse is high for exactly one cycle. It is never asserted while frame_valid was high on the preceding edge.
- done/error rise one cycle after the deciding event (fv_fall or timeout).
  - They fall, and busy stays 0, one cycle after cmd_ack is sampled high.
- Frame edges are detected with one cycle of latency through fv_d.
- Reset mid-sequence clears everything immediately, asynchronously. No pulse is emitted after reset deasserts until a new start_rise.

## Configuration
- CAM_SEQ_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to SKIP and on every fv_rise/fv_fall.
  - It counts in SKIP, ARM, WAIT_START and WAIT_END.
  - When it reaches TIMEOUT_CYCLES − 1 → ERROR.
- CAM_SEQ_TIMEOUT_EN undefined:
  - No watchdog logic; error is tied to 0.
  - The sequence waits indefinitely for frames.

## Test plan
- Reset, then cmd_start 0→1 with SKIP_FRAMES=2 and frames of 100 valid / 20 blank cycles:
  - run_pulse one cycle, one cycle after the edge.
  - capture_pulse once, in the blank after the 2nd frame end.
  - done after the 3rd frame end; frame_count = 3.
- SKIP_FRAMES=0, frame_valid high when start arrives: capture_pulse waits until frame_valid is low, then done after the next complete frame.
- cmd_abort and a new cmd_start edge in the same cycle during WAIT_END → IDLE next cycle, busy=0, no run_pulse.
- cmd_start toggled during SKIP and during DONE → no extra run_pulse. done holds until cmd_ack=1, then clears in 1 cycle.
- With CAM_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50: start, then frame_valid held low → error=1 exactly 50 cycles after entering SKIP, busy=0. Without the macro: busy stays 1 and error stays 0.
- Assert resetN=0 mid-WAIT_START → all outputs 0 immediately. After release, no pulses occur without a fresh cmd_start edge.
